// File: rtl/inst_queue_pkg.sv
// Shared constants and helpers for the decoded-instruction queue.
// Bus width and b_or_j position mirror the CPU-wide decode-bus layout.
package inst_queue_pkg;

    localparam int unsigned DECODE_BUS_WD = 168;
    localparam int unsigned BJ_BIT_IDX    = 121;

    // 2'b10 is not a legal request on either side and counts as nothing.
    function automatic logic [1:0] req_count(input logic [1:0] req);
        case (req)
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Push/pop handshake between the dual decoders (master) and the queue (slave).
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int unsigned DW = DECODE_BUS_WD
);

    logic [1:0]    in_valid;
    logic [DW-1:0] in_inst0;
    logic [DW-1:0] in_inst1;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [DW-1:0] out_inst0;
    logic [DW-1:0] out_inst1;
    logic [1:0]    out_pop;

    modport master (
        output in_valid, in_inst0, in_inst1, out_pop,
        input  in_ready, out_valid, out_inst0, out_inst1
    );

    modport slave (
        input  in_valid, in_inst0, in_inst1, out_pop,
        output in_ready, out_valid, out_inst0, out_inst1
    );

endinterface

// File: rtl/inst_queue.sv
// Dual-push / dual-pop circular instruction queue feeding the two issue slots.
// Also remembers whether the youngest retired entry was a branch/jump.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DW     = DECODE_BUS_WD,
    parameter int unsigned BJ_BIT = BJ_BIT_IDX
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    inst_queue_if.slave            q,
    output logic                   last_pop_bj,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Two free slots are needed to take a full pair.
    localparam logic [CW-1:0] FullThr = CW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [PW-1:0] rptr_nx, wptr_nx;
    logic [CW-1:0] count_q, count_d;
    logic          lbj_q, lbj_d;
    logic [1:0]    npush, npop, pop_req;

    assign rptr_nx = rptr_q + PW'(1);
    assign wptr_nx = wptr_q + PW'(1);

    assign q.in_ready  = count_q < FullThr;
    assign q.out_valid = {count_q >= CW'(2), count_q != '0};
    assign q.out_inst0 = mem_q[rptr_q];
    assign q.out_inst1 = mem_q[rptr_nx];

    assign npush   = q.in_ready ? req_count(q.in_valid) : 2'd0;
    assign pop_req = req_count(q.out_pop);

    always_comb begin
        npop = pop_req;
        if (count_q == '0) begin
            npop = 2'd0;
        end else if (count_q == CW'(1) && pop_req == 2'd2) begin
            npop = 2'd1;
        end
    end

    always_comb begin
        rptr_d  = rptr_q + PW'(npop);
        wptr_d  = wptr_q + PW'(npush);
        count_d = count_q + CW'(npush) - CW'(npop);
        lbj_d   = lbj_q;
        case (npop)
            2'd2:    lbj_d = q.out_inst1[BJ_BIT];
            2'd1:    lbj_d = q.out_inst0[BJ_BIT];
            default: lbj_d = lbj_q;
        endcase
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            lbj_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            lbj_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            lbj_q   <= lbj_d;
        end
    end

    // Storage is not reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (npush != 2'd0) begin
                mem_q[wptr_q] <= q.in_inst0;
            end
            if (npush == 2'd2) begin
                mem_q[wptr_nx] <= q.in_inst1;
            end
        end
    end

    assign count       = count_q;
    assign last_pop_bj = lbj_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-model scoreboard plus a vector table.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = DECODE_BUS_WD;
    localparam int unsigned BJ    = BJ_BIT_IDX;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          last_pop_bj;
    logic [CW-1:0] count;

    inst_queue_if #(.DW(DW)) bus ();

    inst_queue #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .BJ_BIT(BJ)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .q          (bus.slave),
        .last_pop_bj(last_pop_bj),
        .count      (count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sb[$];
    logic          m_lbj;
    int unsigned   seq;
    int            total;
    int            bad;

    typedef struct {
        logic [1:0] iv;
        logic [1:0] pop;
        int         exp_count;
        logic [1:0] exp_valid;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [DW-1:0] mk(input int unsigned s, input logic bj);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]    = s;
        d[63:32]   = ~s;
        d[95:64]   = s * 32'h9e3779b1;
        d[167:160] = s[7:0];
        d[BJ]      = bj;
        return d;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = sb.size();
        chk("count", count, sz);
        chk("out_valid", bus.out_valid, {30'd0, sz >= 2, sz >= 1});
        chk("in_ready", bus.in_ready, sz <= DEPTH - 2);
        chk("last_pop_bj", last_pop_bj, m_lbj);
        if (sz >= 1) chk("out_inst0", bus.out_inst0, sb[0]);
        if (sz >= 2) chk("out_inst1", bus.out_inst1, sb[1]);
    endtask

    // One clock: check current outputs, drive inputs, update model, step.
    task automatic drive(input logic [1:0] iv, input logic [1:0] pop, input logic fl,
                         input logic bj0, input logic bj1, output logic acc);
        logic [DW-1:0] d0, d1;
        int sz, np;
        check_state();
        d0 = mk(seq, bj0);
        d1 = mk(seq + 1, bj1);
        bus.in_valid = iv;
        bus.in_inst0 = d0;
        bus.in_inst1 = d1;
        bus.out_pop  = pop;
        flush        = fl;
        acc = 1'b0;
        sz  = sb.size();
        if (fl) begin
            sb.delete();
            m_lbj = 1'b0;
        end else begin
            np = (pop == 2'b11) ? 2 : (pop == 2'b01) ? 1 : 0;
            if (np > sz) np = sz;
            for (int k = 0; k < np; k++) begin
                m_lbj = sb[0][BJ];
                void'(sb.pop_front());
            end
            if (sz <= DEPTH - 2 && (iv == 2'b01 || iv == 2'b11)) begin
                acc = 1'b1;
                sb.push_back(d0);
                seq++;
                if (iv == 2'b11) begin
                    sb.push_back(d1);
                    seq++;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 2'b00;
        bus.out_pop  = 2'b00;
        flush        = 1'b0;
    endtask

    initial begin
        logic acc;
        int   sent;
        int   guard;
        total = 0;
        bad   = 0;
        seq   = 1;
        m_lbj = 1'b0;
        resetn       = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 2'b00;
        bus.out_pop  = 2'b00;
        bus.in_inst0 = '0;
        bus.in_inst1 = '0;

        tbl[0] = '{2'b00, 2'b00, 0, 2'b00, 1'b1};
        tbl[1] = '{2'b10, 2'b00, 0, 2'b00, 1'b1};
        tbl[2] = '{2'b11, 2'b00, 2, 2'b11, 1'b1};
        tbl[3] = '{2'b00, 2'b10, 2, 2'b11, 1'b1};
        tbl[4] = '{2'b01, 2'b01, 2, 2'b11, 1'b1};
        tbl[5] = '{2'b00, 2'b11, 0, 2'b00, 1'b1};
        tbl[6] = '{2'b00, 2'b11, 0, 2'b00, 1'b1};
        tbl[7] = '{2'b01, 2'b00, 1, 2'b01, 1'b1};
        tbl[8] = '{2'b00, 2'b11, 0, 2'b00, 1'b1};

        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_valid", bus.out_valid, 2'b00);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_lbj", last_pop_bj, 1'b0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].pop, 1'b0, 1'b0, 1'b0, acc);
            chk($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d_ready", i), bus.in_ready, tbl[i].exp_ready);
        end

        // Fill to DEPTH-1, then a dropped pair, then a pop with a blocked push.
        repeat (7) drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, acc);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, acc);
        chk("full_count", count, 15);
        chk("full_ready", bus.in_ready, 1'b0);
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, acc);
        chk("drop_count", count, 15);
        drive(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, acc);
        chk("pop_full_count", count, 14);
        chk("pop_full_ready", bus.in_ready, 1'b1);
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, acc);
            guard++;
        end
        chk("drain_empty", count, 0);

        // 40 pairs with mixed pops, wrapping the pointers several times.
        sent  = 0;
        guard = 0;
        while ((sent < 40 || sb.size() > 0) && guard < 400) begin
            logic [1:0] pop;
            case ($urandom_range(0, 2))
                0:       pop = 2'b00;
                1:       pop = 2'b01;
                default: pop = 2'b11;
            endcase
            drive((sent < 40) ? 2'b11 : 2'b00, pop, 1'b0, 1'b0, 1'b0, acc);
            if (acc) sent++;
            guard++;
        end
        chk("wrap_done", {sent == 40, sb.size() == 0}, 2'b11);

        // Branch J then delay-slot S.
        drive(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, acc);
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, acc);
        chk("bj_after_j", last_pop_bj, 1'b1);
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, acc);
        chk("bj_after_s", last_pop_bj, 1'b0);

        // Flush at count 6 with concurrent push and pop.
        drive(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, acc);
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, acc);
        drive(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, acc);
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, acc);
        chk("pre_flush_count", count, 6);
        chk("pre_flush_lbj", last_pop_bj, 1'b1);
        drive(2'b11, 2'b11, 1'b1, 1'b0, 1'b0, acc);
        chk("flush_count", count, 0);
        chk("flush_valid", bus.out_valid, 2'b00);
        chk("flush_lbj", last_pop_bj, 1'b0);
        drive(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, acc);
        drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, acc);
        chk("post_flush_lbj", last_pop_bj, 1'b0);

        // Asynchronous reset while occupied.
        drive(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, acc);
        drive(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, acc);
        chk("pre_rst_lbj", last_pop_bj, 1'b1);
        resetn = 1'b0;
        #2;
        chk("arst_count", count, 0);
        chk("arst_valid", bus.out_valid, 2'b00);
        chk("arst_lbj", last_pop_bj, 1'b0);
        sb.delete();
        m_lbj = 1'b0;
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, acc);
        check_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Decoded-instruction queue between the dual decoders and the two `issue_sub` slots of the dual-issue pipeline. It accepts up to two decode-bus entries per cycle and presents the two oldest entries to issue. It retires 0, 1 or 2 entries per cycle according to the issue pop request. It also tracks whether the most recently retired instruction was a branch/jump, so issue can mark delay slots.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, at least 4.
- `DW`, `DECODE_BUS_WD` (168): decode-bus width.
- `BJ_BIT`, 121: index of `b_or_j` inside a decode-bus entry.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: the single clock.
  - `resetn` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous clear, for exception, eret or mispredict.
- `in_valid` in 2: push request.
  - Bit 0 is the older entry.
  - `2'b10` is illegal and is treated as `2'b00`.
- `in_inst0`, `in_inst1` in DW: entries to push.
- `in_ready` out 1: at least two slots are free.
- `out_valid` out 2: head entries present.
  - Bit 0 is the oldest.
  - `out_valid[1]` implies `out_valid[0]`.
- `out_inst0`, `out_inst1` out DW: oldest and second-oldest entries.
- `out_pop` in 2: issue consumes entries.
  - `2'b01` pops one entry.
  - `2'b11` pops two entries.
  - `2'b10` is treated as `2'b00`.
- `last_pop_bj` out 1: the youngest instruction retired so far had `b_or_j` set. Drives `preinst_is_bj`.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: circular buffer of DEPTH entries, with read pointer `rptr` and write pointer `wptr`. Both are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Accepted push count `npush`:
  - Derived from `in_valid` (0/1/2), gated by `in_ready`.
  - When `in_ready`=0, pushes are dropped; upstream must hold its entries.
  - `in_inst0` is written at `wptr` and `in_inst1` at `wptr+1`. `wptr` advances by `npush`.
- Effective pop count `npop`:
  - Derived from `out_pop` (0/1/2), clipped to the valid head count. A pop of an empty slot is ignored.
  - `rptr` advances by `npop`.
- `count` next value = `count + npush - npop`. It never exceeds DEPTH and never underflows.
- Head outputs:
  - `out_inst0` = mem[`rptr`]; `out_inst1` = mem[`rptr+1`].
  - `out_valid` = {`count`>=2, `count`>=1}.
  - Data outputs are don't-care when the matching valid bit is low.
- `last_pop_bj`:
  - On `npop`=2 it loads `out_inst1[BJ_BIT]`.
  - On `npop`=1 it loads `out_inst0[BJ_BIT]`.
  - Otherwise it holds.
- `flush` has priority over push and pop in the same cycle:
  - `rptr`, `wptr`, `count` and `last_pop_bj` are cleared to 0.
  - Same-cycle pushes are discarded.
  - Memory contents are not cleared.

## Timing
- Reset values: `rptr`, `wptr`, `count` = 0; `out_valid`=2'b00; `in_ready`=1; `last_pop_bj`=0. Reset is async assert, sync deassert at the top level.
- Push-to-head latency is 1 cycle. There is no same-cycle bypass from `in_inst*` to `out_inst*`.
- `in_ready` and `out_valid` are combinational from registered `count` only, so there is no combinational path from `in_valid` or `out_pop`.
- Simultaneous push and pop in one cycle is legal at any occupancy. `in_ready` uses pre-pop occupancy (conservative).
- Full boundary: `count`=DEPTH-1 deasserts `in_ready` (fewer than two slots free), even if a pop happens in that cycle.
- Wrap: pointer arithmetic is modulo DEPTH. A two-entry write or read straddling index DEPTH-1 → 0 is legal.
- `flush` and `resetn` mid-operation: the queue reads empty on the next cycle.

## Structure
- `DECODE_BUS_WD` and the `b_or_j` bit index (`BJ_BIT`) live in shared `mycpu.h`.
- No sub-module. Storage is a register array with two write ports and two combinational read ports, inlined.
- Pointer and count update is one `always` block on `clk`/`negedge resetn`.

## Test plan
- Reset then idle → `out_valid`=00, `in_ready`=1, `count`=0, `last_pop_bj`=0.
- Push A,B (in_valid=11); next cycle pop 11 → `out_inst0`=A and `out_inst1`=B while present; `count` goes 2 then 0.
- Push pairs until `count`=15 → `in_ready`=0. A further push of 11 is dropped and `count` stays 15. Pop 01 → `count`=14, `in_ready`=1.
- Cycle 40 pairs through the queue with mixed pop 01/11 → FIFO order preserved across the 15→0 wrap; pop 11 with `count`=1 retires only one entry.
- Pop branch J (b_or_j=1) alone → `last_pop_bj`=1. Then pop slot instruction S (b_or_j=0) → `last_pop_bj`=0.
- `count`=6, assert `flush` with in_valid=11 and out_pop=11 → next cycle `count`=0, `out_valid`=00, `last_pop_bj`=0; the new entries are absent.
